// File: rtl/zero_run_monitor.sv
// zero_run_monitor
// Watches the qualified is_zero flag from the upstream zero detector. It tracks
// the current run of consecutive zero samples, the longest run seen and the
// total number of zero samples. When a run reaches RUN_THRESH it raises a level
// alarm and a one-cycle entry pulse for the status/interrupt logic.
// Every output comes straight from a flop, so there is one cycle of latency
// from an accepted sample to the outputs.

module zero_run_monitor #(
  parameter int CNT_W      = 8,
  parameter int TOTAL_W    = 16,
  parameter int RUN_THRESH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               is_zero,
  input  logic               clear,
  output logic [CNT_W-1:0]   run_len,
  output logic [CNT_W-1:0]   max_run,
  output logic [TOTAL_W-1:0] zero_total,
  output logic               alarm,
  output logic               alarm_pulse,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  // Saturation limits and constant increments, sized to their counters.
  localparam logic [CNT_W-1:0]   RUN_MAX   = '1;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;
  localparam logic [CNT_W-1:0]   RUN_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TOTAL_W-1:0] TOTAL_ONE = {{(TOTAL_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]     RUN_ONE_W = {{CNT_W{1'b0}}, 1'b1};
  // One bit wider than run_len so that run_len+1 can never wrap in the compare.
  localparam logic [CNT_W:0]     THRESH    = RUN_THRESH[CNT_W:0];

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     run_len_q, run_len_d;
  logic [CNT_W-1:0]     max_run_q, max_run_d;
  logic [TOTAL_W-1:0]   zero_total_q, zero_total_d;
  logic                 alarm_q, alarm_d;
  logic                 alarm_pulse_q, alarm_pulse_d;

  // A sample counts only when it is valid and not cancelled by clear.
  logic                 sample_ok;
  logic                 zero_ok;
  logic                 nonzero_ok;
  logic [CNT_W:0]       run_plus_one;
  logic                 thresh_hit;
  logic [CNT_W-1:0]     run_len_sat_inc;
  logic [TOTAL_W-1:0]   zero_total_sat_inc;

  assign sample_ok    = in_valid & ~clear;
  assign zero_ok      = sample_ok & is_zero;
  assign nonzero_ok   = sample_ok & ~is_zero;
  assign run_plus_one = {1'b0, run_len_q} + RUN_ONE_W;
  assign thresh_hit   = (run_plus_one >= THRESH);

  // Saturating increments for the two counters; they stick at all-ones.
  always_comb begin
    run_len_sat_inc    = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_ONE;
    zero_total_sat_inc = (zero_total_q == TOTAL_MAX) ? zero_total_q
                                                     : zero_total_q + TOTAL_ONE;
  end

  // Current run length and total zero count.
  always_comb begin
    run_len_d    = run_len_q;
    zero_total_d = zero_total_q;
    if (clear) begin
      run_len_d    = '0;
      zero_total_d = '0;
    end else if (zero_ok) begin
      run_len_d    = run_len_sat_inc;
      zero_total_d = zero_total_sat_inc;
    end else if (nonzero_ok) begin
      run_len_d    = '0;
    end
  end

  // Longest run: compared against the run length that this sample produces.
  always_comb begin
    max_run_d = max_run_q;
    if (clear) begin
      max_run_d = '0;
    end else if (sample_ok && (run_len_d > max_run_q)) begin
      max_run_d = run_len_d;
    end
  end

  // Run/alarm state machine; only an accepted sample moves it.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (sample_ok) begin
      unique case (state_q)
        ST_IDLE: begin
          // With a threshold of one the first zero already trips the alarm.
          if (is_zero) state_d = thresh_hit ? ST_ALARM : ST_RUN;
        end
        ST_RUN: begin
          if (!is_zero)        state_d = ST_IDLE;
          else if (thresh_hit) state_d = ST_ALARM;
        end
        ST_ALARM: begin
          // A saturated run keeps the alarm; only a nonzero sample ends it.
          if (!is_zero) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Alarm level follows the next state; the pulse marks a fresh entry only.
  always_comb begin
    alarm_d       = (state_d == ST_ALARM);
    alarm_pulse_d = sample_ok && (state_d == ST_ALARM) && (state_q != ST_ALARM);
  end

  // All state and outputs register here; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      run_len_q     <= '0;
      max_run_q     <= '0;
      zero_total_q  <= '0;
      alarm_q       <= 1'b0;
      alarm_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_len_q     <= run_len_d;
      max_run_q     <= max_run_d;
      zero_total_q  <= zero_total_d;
      alarm_q       <= alarm_d;
      alarm_pulse_q <= alarm_pulse_d;
    end
  end

  assign run_len     = run_len_q;
  assign max_run     = max_run_q;
  assign zero_total  = zero_total_q;
  assign alarm       = alarm_q;
  assign alarm_pulse = alarm_pulse_q;
  assign state       = state_q;

endmodule

// File: tb/tb_zero_run_monitor.sv
// Bench for zero_run_monitor. Two instances share one stimulus stream:
// inst0 uses the default widths with threshold 3, and inst1 uses CNT_W=2,
// TOTAL_W=4 and threshold 1, so it reaches saturation quickly. The reference
// model keeps the run as an unbounded integer count and derives every output
// from it, so saturation and state come from plain min/compare arithmetic.

module tb_zero_run_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic is_zero = 1'b0;
  logic clear = 1'b0;

  logic [7:0]  run_len0, max_run0;
  logic [15:0] zt0;
  logic        al0, ap0;
  logic [1:0]  st0;

  logic [1:0]  run_len1, max_run1;
  logic [3:0]  zt1;
  logic        al1, ap1;
  logic [1:0]  st1;

  zero_run_monitor #(.CNT_W(8), .TOTAL_W(16), .RUN_THRESH(3)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .is_zero(is_zero), .clear(clear),
    .run_len(run_len0), .max_run(max_run0), .zero_total(zt0),
    .alarm(al0), .alarm_pulse(ap0), .state(st0)
  );

  zero_run_monitor #(.CNT_W(2), .TOTAL_W(4), .RUN_THRESH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .is_zero(is_zero), .clear(clear),
    .run_len(run_len1), .max_run(max_run1), .zero_total(zt1),
    .alarm(al1), .alarm_pulse(ap1), .state(st1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int txn = 0;

  // Model state per instance: r is the true run count, t the true zero count.
  int r[2];
  int t[2];
  int m[2];
  bit p[2];
  int maxc[2] = '{255, 3};
  int maxt[2] = '{65535, 15};
  int thr[2]  = '{3, 1};

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_run(input int i);
    return imin(r[i], maxc[i]);
  endfunction

  function automatic int exp_total(input int i);
    return imin(t[i], maxt[i]);
  endfunction

  function automatic int exp_state(input int i);
    if (r[i] == 0) return 0;
    return (r[i] >= thr[i]) ? 2 : 1;
  endfunction

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply what the DUTs saw at the edge just taken.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst || clear) begin
        r[i] = 0; t[i] = 0; m[i] = 0; p[i] = 1'b0;
      end else if (in_valid) begin
        bit was_alarm;
        was_alarm = (r[i] >= thr[i]);
        if (is_zero) begin
          r[i]++;
          t[i]++;
        end else begin
          r[i] = 0;
        end
        if (exp_run(i) > m[i]) m[i] = exp_run(i);
        p[i] = (r[i] >= thr[i]) && !was_alarm;
      end else begin
        p[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rs, input bit v, input bit z, input bit cl);
    rst = rs; in_valid = v; is_zero = z; clear = cl;
    @(posedge clk);
    #1;
    model_update();
    txn++;
    $display("txn %0d rst=%0b v=%0b z=%0b clr=%0b | run_len=%0d/%0d state=%0d/%0d total=%0d/%0d",
             txn, rs, v, z, cl, run_len0, run_len1, st0, st1, zt0, zt1);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_lit("inst0 run_len",     int'(run_len0), exp_run(0));
      check_lit("inst0 max_run",     int'(max_run0), m[0]);
      check_lit("inst0 zero_total",  int'(zt0),      exp_total(0));
      check_lit("inst0 state",       int'(st0),      exp_state(0));
      check_lit("inst0 alarm",       int'(al0),      int'(exp_state(0) == 2));
      check_lit("inst0 alarm_pulse", int'(ap0),      int'(p[0]));
      check_lit("inst1 run_len",     int'(run_len1), exp_run(1));
      check_lit("inst1 max_run",     int'(max_run1), m[1]);
      check_lit("inst1 zero_total",  int'(zt1),      exp_total(1));
      check_lit("inst1 state",       int'(st1),      exp_state(1));
      check_lit("inst1 alarm",       int'(al1),      int'(exp_state(1) == 2));
      check_lit("inst1 alarm_pulse", int'(ap1),      int'(p[1]));
    end
  end

  int pulses;

  initial begin
    for (int i = 0; i < 2; i++) begin
      r[i] = 0; t[i] = 0; m[i] = 0; p[i] = 1'b0;
    end

    // Reset state.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0, 0);
    check_lit("reset run_len", int'(run_len0), 0);
    check_lit("reset max_run", int'(max_run0), 0);
    check_lit("reset total",   int'(zt0), 0);
    check_lit("reset state",   int'(st0), 0);
    check_lit("reset alarm",   int'(al0), 0);
    check_lit("reset pulse",   int'(ap0), 0);

    // Z,Z,Z,N with threshold 3.
    step(0, 1, 1, 0);
    check_lit("zzzn run1", int'(run_len0), 1); check_lit("zzzn st1", int'(st0), 1);
    check_lit("zzzn ap1", int'(ap0), 0);
    step(0, 1, 1, 0);
    check_lit("zzzn run2", int'(run_len0), 2); check_lit("zzzn st2", int'(st0), 1);
    check_lit("zzzn ap2", int'(ap0), 0);
    step(0, 1, 1, 0);
    check_lit("zzzn run3", int'(run_len0), 3); check_lit("zzzn st3", int'(st0), 2);
    check_lit("zzzn ap3", int'(ap0), 1); check_lit("zzzn al3", int'(al0), 1);
    step(0, 1, 0, 0);
    check_lit("zzzn run4", int'(run_len0), 0); check_lit("zzzn st4", int'(st0), 0);
    check_lit("zzzn ap4", int'(ap0), 0);
    check_lit("zzzn max", int'(max_run0), 3); check_lit("zzzn total", int'(zt0), 3);

    // Gap in in_valid does not break a run.
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1'($urandom_range(0, 1)), 0);
      check_lit("gap hold run", int'(run_len0), 2);
      check_lit("gap hold st",  int'(st0), 1);
    end
    step(0, 1, 1, 0);
    check_lit("gap run3", int'(run_len0), 3); check_lit("gap st", int'(st0), 2);
    check_lit("gap ap", int'(ap0), 1); check_lit("gap total", int'(zt0), 6);

    // Two alarm entries; CNT_W=2 instance saturates during the first run.
    step(0, 0, 0, 1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1, 0);
      pulses += int'(ap0);
    end
    check_lit("sat2 run_len", int'(run_len1), 3);
    check_lit("sat2 state",   int'(st1), 2);
    check_lit("sat2 max_run", int'(max_run1), 3);
    check_lit("sat2 total",   int'(zt1), 5);
    step(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 0);
      pulses += int'(ap0);
    end
    check_lit("two entries pulses", pulses, 2);
    check_lit("two entries max",    int'(max_run0), 5);
    check_lit("two entries total",  int'(zt0), 8);
    check_lit("two entries run",    int'(run_len0), 3);

    // clear with a valid Z while in ALARM at run_len=4.
    step(0, 1, 1, 0);
    check_lit("pre-clear run", int'(run_len0), 4);
    step(0, 1, 1, 1);
    check_lit("clear run",   int'(run_len0), 0); check_lit("clear max", int'(max_run0), 0);
    check_lit("clear total", int'(zt0), 0);      check_lit("clear st",  int'(st0), 0);
    check_lit("clear al",    int'(al0), 0);      check_lit("clear ap",  int'(ap0), 0);

    // rst mid-run with a valid Z present.
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    check_lit("pre-rst st", int'(st0), 1);
    step(1, 1, 1, 0);
    check_lit("rst run", int'(run_len0), 0); check_lit("rst total", int'(zt0), 0);
    check_lit("rst st",  int'(st0), 0);      check_lit("rst ap",    int'(ap0), 0);
    step(0, 1, 1, 0);
    check_lit("post-rst run", int'(run_len0), 1);

    // Long run: 8-bit run_len saturates at 255 and stays in ALARM.
    for (int k = 0; k < 300; k++) step(0, 1, 1, 0);
    check_lit("sat8 run_len", int'(run_len0), 255);
    check_lit("sat8 state",   int'(st0), 2);
    check_lit("sat8 max_run", int'(max_run0), 255);

    // Randomised traffic checked by the per-cycle compare.
    for (int n = 0; n < 2000; n++) begin
      step(1'($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 199) == 0));
    end

    step(0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zero_run_monitor.md
Name: zero_run_monitor

Overview:
- Downstream consumer of the 8-bit zero detector's is_zero flag.
- Samples the flag under a valid qualifier and tracks consecutive-zero runs.
- Keeps running statistics: current run length, longest run, total zero count.
- Raises a level alarm plus a one-cycle entry pulse when a run reaches a programmable threshold. Feeds the status/interrupt logic.

Parameters:
- CNT_W, 8, width of run_len and max_run counters.
- TOTAL_W, 16, width of zero_total counter.
- RUN_THRESH, 3, run length at which the alarm asserts. Legal range 1..(2^CNT_W - 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies is_zero; sample taken only when high.
- is_zero  input  1  zero flag from upstream detector.
- clear  input  1  synchronous soft clear of all counters and the FSM.
- run_len  output  CNT_W  current consecutive-zero count.
- max_run  output  CNT_W  longest run observed since reset/clear.
- zero_total  output  TOTAL_W  total valid zero samples since reset/clear.
- alarm  output  1  high while FSM is in ALARM.
- alarm_pulse  output  1  one-cycle pulse on entry to ALARM.
- state  output  2  FSM state: IDLE=0, RUN=1, ALARM=2 (3 unused).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - run_len=0, max_run=0, zero_total=0.
  - alarm=0, alarm_pulse=0, state=IDLE.
- Priority: rst > clear > sample.
  - clear has the same effect as rst.
  - A valid sample in the same cycle as clear is discarded, not counted.
- Registering and latency:
  - All outputs are registered.
  - A sample accepted at edge N is reflected in the outputs immediately after edge N (1-cycle latency from input setup).
- in_valid=0: every register holds, except alarm_pulse, which returns to 0.
- FSM, evaluated only when in_valid=1:
  - IDLE, is_zero=1: go to RUN. If RUN_THRESH=1, go directly to ALARM instead.
  - IDLE, is_zero=0: stay in IDLE.
  - RUN, is_zero=1: if run_len+1 >= RUN_THRESH go to ALARM, else stay in RUN.
  - RUN, is_zero=0: go to IDLE.
  - ALARM, is_zero=1: stay in ALARM.
  - ALARM, is_zero=0: go to IDLE.
- run_len:
  - Increments on a valid zero sample.
  - Reset to 0 on a valid nonzero sample.
  - Saturates at 2^CNT_W-1; the FSM remains in ALARM once saturated.
- max_run:
  - Updated each accepted sample to max(max_run, next run_len).
  - Never decreases except on rst/clear.
- zero_total:
  - Increments on each valid zero sample.
  - Saturates at 2^TOTAL_W-1; no wrap.
- alarm = (state==ALARM).
- alarm_pulse:
  - High for exactly one cycle after the transition into ALARM.
  - Not re-asserted while the FSM stays in ALARM.
  - Re-asserts on every fresh entry.
- Gaps in in_valid do not break a run. Only a valid nonzero sample ends a run.
- Reset or clear mid-run or in ALARM: outputs return to reset values on the next edge. alarm_pulse must not fire as a result.

Test Plan:
- Reset, then valid samples Z,Z,Z,N (Z=is_zero 1, N=0), RUN_THRESH=3:
  - run_len goes 1,2,3,0; state goes RUN,RUN,ALARM,IDLE.
  - alarm_pulse is high only after the third sample.
  - max_run=3, zero_total=3.
- Samples Z,Z, then in_valid=0 for 4 cycles, then Z:
  - Outputs hold through the gap.
  - After the third Z: run_len=3 and ALARM is entered.
- Run of 5 zeros, then N, then a run of 3 zeros:
  - alarm_pulse fires twice (once per entry).
  - max_run=5, zero_total=8, final run_len=3.
- clear asserted together with a valid Z while in ALARM with run_len=4:
  - Next cycle: all counters 0, state IDLE, alarm=0, alarm_pulse=0. The Z is not counted.
- CNT_W=2, 5 consecutive zeros:
  - run_len saturates at 3, state stays ALARM, max_run=3, zero_total=5.
- rst asserted mid-run (run_len=2, state RUN) with in_valid=1, is_zero=1:
  - All outputs reach reset values on the next edge.
  - First Z after reset yields run_len=1.
